// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 op encodings,
// sequencer states and the shared-ALU operation word.
package muldiv_sequencer_pkg;

    localparam int unsigned XLEN = 32;

    // Shared integer ALU operation word; bits may be combined (SUB | SLTU_B).
    typedef logic [3:0] InstructionSetALU;
    localparam InstructionSetALU ALU_NOP    = 4'b0000;
    localparam InstructionSetALU ALU_ADD    = 4'b0001;
    localparam InstructionSetALU ALU_SUB    = 4'b0010;
    localparam InstructionSetALU ALU_SLTU_B = 4'b0100;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } seq_state_e;

    function automatic logic is_div_op(input muldiv_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    function automatic logic signed_a(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic signed_b(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_sequencer_sign_fix.sv
// Conditional two's-complement negation: operand magnitude at request latch,
// product/quotient/remainder sign correction in FIX.
module muldiv_sign_fix
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    always_comb begin
        val_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer driving the shared ALU one bit-step per grant.
// Optional MULDIV_FASTPATH_EN: trivial operands (mul by 0, div by 0 or 1) skip the ALU.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ITERATIONS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic             alu_req,
    input  logic             alu_gnt,
    output InstructionSetALU alu_op,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [XLEN-1:0]  alu_in1_b,
    output logic [XLEN-1:0]  alu_in2_b,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_out_b
);

    localparam int unsigned CW = $clog2(ITERATIONS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    seq_state_e      state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;      // mul: acc_hi   / div: partial remainder
    logic [XLEN-1:0] lo_q, lo_d;      // mul: mplier   / div: dividend -> quotient
    logic [XLEN-1:0] opnd_q, opnd_d;  // mul: mcand    / div: divisor
    logic [XLEN-1:0] resp_q, resp_d;
    logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    muldiv_op_e      req_op_e;
    logic            req_neg_a, req_neg_b;
    logic [XLEN-1:0] req_abs_a, req_abs_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic [XLEN-1:0] rem_s;
    logic            carry, take;

    always_comb begin
        req_op_e  = muldiv_op_e'(req_op);
        req_neg_a = signed_a(req_op_e) & req_a[XLEN-1];
        req_neg_b = signed_b(req_op_e) & req_b[XLEN-1];
    end

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (
        .val_i (req_a),
        .neg_i (req_neg_a),
        .val_o (req_abs_a)
    );

    muldiv_sign_fix #(.W(XLEN)) u_abs_b (
        .val_i (req_b),
        .neg_i (req_neg_b),
        .val_o (req_abs_b)
    );

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .val_i ({hi_q, lo_q}),
        .neg_i (neg_a_q ^ neg_b_q),
        .val_o (prod_fix)
    );

    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
    muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
        .val_i (lo_q),
        .neg_i ((neg_a_q ^ neg_b_q) && (opnd_q != '0)),
        .val_o (quo_fix)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
        .val_i (hi_q),
        .neg_i (neg_a_q),
        .val_o (rem_fix)
    );

`ifdef MULDIV_FASTPATH_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (!is_div_op(req_op_e)) begin
            fast_hit = (req_a == '0) || (req_b == '0);
        end else if (req_b == '0) begin
            fast_hit = 1'b1;
            fast_res = req_op[1] ? req_a : '1;
        end else if (req_b == XLEN'(1)) begin
            fast_hit = 1'b1;
            fast_res = req_op[1] ? '0 : req_a;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opnd_d     = opnd_q;
        resp_d     = resp_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_req    = 1'b0;
        alu_op     = ALU_NOP;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_in1_b  = '0;
        alu_in2_b  = '0;
        rem_s      = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        carry      = 1'b0;
        take       = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !kill) begin
                    op_d    = req_op_e;
                    neg_a_d = req_neg_a;
                    neg_b_d = req_neg_b;
                    hi_d    = '0;
                    lo_d    = req_abs_a;
                    opnd_d  = req_abs_b;
                    cnt_d   = '0;
                    state_d = S_ITER;
`ifdef MULDIV_FASTPATH_EN
                    if (fast_hit) begin
                        resp_d  = fast_res;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_ITER: begin
                alu_req = 1'b1;
                if (is_div_op(op_q)) begin
                    alu_op    = ALU_SUB | ALU_SLTU_B;
                    alu_in1   = rem_s;
                    alu_in1_b = rem_s;
                    alu_in2   = opnd_q;
                    alu_in2_b = opnd_q;
                    // A set rem MSB means the 33-bit shifted value exceeds any divisor.
                    take      = hi_q[XLEN-1] || !alu_out_b;
                end else begin
                    alu_op  = ALU_ADD;
                    alu_in1 = hi_q;
                    alu_in2 = lo_q[0] ? opnd_q : '0;
                    carry   = (alu_out < hi_q);
                end
                if (alu_gnt) begin
                    if (is_div_op(op_q)) begin
                        hi_d = take ? alu_out : rem_s;
                        lo_d = {lo_q[XLEN-2:0], take};
                    end else begin
                        {hi_d, lo_d} = {carry, alu_out, lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL:                       resp_d = prod_fix[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: resp_d = prod_fix[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              resp_d = quo_fix;
                    default:                      resp_d = rem_fix;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            resp_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            resp_q  <= resp_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign resp_data = resp_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural shared-ALU model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             kill;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic             alu_req;
    logic             alu_gnt;
    InstructionSetALU alu_op;
    logic [31:0]      alu_in1, alu_in2, alu_in1_b, alu_in2_b;
    logic [31:0]      alu_out;
    logic             alu_out_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    assign alu_out   = ((alu_op & ALU_ADD) != '0) ? (alu_in1 + alu_in2) :
                       ((alu_op & ALU_SUB) != '0) ? (alu_in1 - alu_in2) : 32'd0;
    assign alu_out_b = (alu_in1_b < alu_in2_b);

    muldiv_sequencer #(.XLEN(32), .ITERATIONS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_op     (alu_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_in1_b  (alu_in1_b),
        .alu_in2_b  (alu_in2_b),
        .alu_out    (alu_out),
        .alu_out_b  (alu_out_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic fast_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
        return op[2] ? ((b == 32'd0) || (b == 32'd1)) : ((a == 32'd0) || (b == 32'd0));
`else
        return 1'b0;
`endif
    endfunction

    // Issue one op, grant with probability pct%, check latency/result, optionally hold, release.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int unsigned pct, input int unsigned hold);
        int unsigned cyc, grants, exp_cyc;
        logic fast, saw_req;
        fast    = fast_of(op, a, b);
        exp_cyc = fast ? 1 : 0;
        grants  = 0;
        saw_req = 1'b0;
        @(negedge clk);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = 1'b0;
        alu_gnt    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 500) begin
            saw_req = saw_req | alu_req;
            alu_gnt = ($urandom_range(0, 99) < pct);
            if (!fast && grants < 32 && alu_gnt) begin
                grants++;
                if (grants == 32) exp_cyc = cyc + 2;
            end
            @(negedge clk);
            cyc++;
        end
        alu_gnt = 1'b0;
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " data"}, resp_data, exp);
        check({tag, " alu_req seen"}, {31'd0, saw_req}, {31'd0, !fast});
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, " hold data"}, resp_data, exp);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " released"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int unsigned seen;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0;
        kill = 1'b0; resp_ready = 1'b0; alu_gnt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst req_ready",  {31'd0, req_ready},  32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_data",  resp_data,           32'd0);
        check("rst alu_req",    {31'd0, alu_req},    32'd0);
        check("rst alu_op",     {28'd0, alu_op},     32'd0);
        check("rst alu_in1",    alu_in1,             32'd0);
        reset = 1'b0;

        run_op("mul 7*6",          OP_MUL,    32'd7,        32'd6,        32'd42,       100, 5);
        run_op("mulh -1*-1",       OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 100, 0);
        run_op("mulhu max*max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 100, 0);
        run_op("mulhsu -1*2",      OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 100, 0);
        run_op("div -7/2",         OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 100, 0);
        run_op("rem -7/2",         OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 100, 0);
        run_op("div 7/-2",         OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 100, 0);
        run_op("rem 7/-2",         OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        100, 0);
        run_op("divu 100/0",       OP_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 100, 0);
        run_op("remu 100/0",       OP_REMU,   32'd100,      32'd0,        32'd100,      100, 0);
        run_op("div -7/0",         OP_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 100, 0);
        run_op("div ovf",          OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 100, 0);
        run_op("rem ovf",          OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        100, 0);
        run_op("rnd div -7/2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 50,  0);
        run_op("rnd mulhu 2^16^2", OP_MULHU,  32'h00010000, 32'h00010000, 32'd1,        50,  0);
        run_op("rnd mul 2^16^2",   OP_MUL,    32'h00010000, 32'h00010000, 32'd0,        50,  0);
        run_op("rnd remu 100/7",   OP_REMU,   32'd100,      32'd7,        32'd2,        50,  2);
        run_op("divu 9/1",         OP_DIVU,   32'd9,        32'd1,        32'd9,        100, 0);

        // Kill after ten granted steps.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd7; req_b = 32'd6; alu_gnt = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("kill pre alu_req", {31'd0, alu_req}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill alu_req",    {31'd0, alu_req},    32'd0);
        check("kill req_ready",  {31'd0, req_ready},  32'd1);
        check("kill resp_valid", {31'd0, resp_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("kill no resp", seen, 32'd0);

        // Kill together with a request in IDLE: the request must not be taken.
        kill = 1'b1; req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd50; req_b = 32'd3;
        @(negedge clk);
        kill = 1'b0; req_valid = 1'b0;
        check("idle kill req_ready", {31'd0, req_ready}, 32'd1);
        check("idle kill alu_req",   {31'd0, alu_req},   32'd0);
        alu_gnt = 1'b0;

        run_op("mul 3*5", OP_MUL, 32'd3, 32'd5, 32'd15, 100, 0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'hFFFFFFFF; req_b = 32'd3; alu_gnt = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst alu_req",   {31'd0, alu_req},   32'd0);
        check("arst req_ready", {31'd0, req_ready}, 32'd1);
        check("arst resp_data", resp_data,          32'd0);
        check("arst alu_op",    {28'd0, alu_op},    32'd0);
        check("arst alu_in1",   alu_in1,            32'd0);
        @(negedge clk);
        reset = 1'b0; alu_gnt = 1'b0;

        run_op("post-rst divu", OP_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
